// File: rtl/uart_pkg.sv
// Shared UART constants and types: receiver state encoding, default frame width and the
// baud divider values used by uart_speed_select and the receive/transmit controllers.
package uart_pkg;

    localparam int CLK_HZ        = 50_000_000;
    localparam int BAUD          = 115_200;
    localparam int BPS_DIV       = CLK_HZ / BAUD - 1;
    localparam int BPS_HALF      = BPS_DIV / 2;
    localparam int DEF_DATA_BITS = 8;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Synchronises the asynchronous rx line and flags its falling edge (start-bit candidate).
// Latency SYNC_STAGES cycles; all flops reset to 1 so reset release never looks like an edge.
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rx_in,
    output logic rx_s,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];
    assign fall = prev_q & ~rx_s;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receiver: samples each bit on the mid-bit clk_bps tick, byte appears 1 cycle after the stop tick.
// Output held on rx_valid until rx_ready; a good frame arriving while still held is dropped and flagged.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = DEF_DATA_BITS,
    parameter int SYNC_STAGES = 2,
    parameter int PARITY_EN   = 0,
    parameter int PARITY_ODD  = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_in,
    input  logic                 clk_bps,
    output logic                 bps_start,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun
);

    localparam int                 CNT_W    = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DATA_BITS - 1);
    localparam logic               ODD      = (PARITY_ODD != 0);

    logic rx_s;
    logic fall;

    uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .rx_in (rx_in),
        .rx_s  (rx_s),
        .fall  (fall)
    );

    rx_state_t              state_q, state_d;
    logic                   bps_q, bps_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic                   par_q, par_d;
    logic                   perr_q, perr_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   ferr_q, ferr_d;
    logic                   perr_p_q, perr_p_d;
    logic                   ovr_q, ovr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RX_IDLE;
            bps_q    <= 1'b0;
            cnt_q    <= '0;
            shreg_q  <= '0;
            par_q    <= 1'b0;
            perr_q   <= 1'b0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            ferr_q   <= 1'b0;
            perr_p_q <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            bps_q    <= bps_d;
            cnt_q    <= cnt_d;
            shreg_q  <= shreg_d;
            par_q    <= par_d;
            perr_q   <= perr_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            ferr_q   <= ferr_d;
            perr_p_q <= perr_p_d;
            ovr_q    <= ovr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        bps_d    = bps_q;
        cnt_d    = cnt_q;
        shreg_d  = shreg_q;
        par_d    = par_q;
        perr_d   = perr_q;
        data_d   = data_q;
        valid_d  = valid_q;
        ferr_d   = 1'b0;
        perr_p_d = 1'b0;
        ovr_d    = 1'b0;

        // A same-cycle accept frees the slot, so a landing byte below overrides this clear.
        if (valid_q && rx_ready) valid_d = 1'b0;

        case (state_q)
            RX_IDLE: begin
                if (fall) begin
                    state_d = RX_START;
                    bps_d   = 1'b1;
                end
            end
            RX_START: begin
                if (clk_bps) begin
                    if (!rx_s) begin
                        state_d = RX_DATA;
                        cnt_d   = '0;
                        par_d   = 1'b0;
                        perr_d  = 1'b0;
                    end else begin
                        state_d = RX_IDLE;
                        bps_d   = 1'b0;
                    end
                end
            end
            RX_DATA: begin
                if (clk_bps) begin
                    shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
                    par_d   = par_q ^ rx_s;
                    if (cnt_q == CNT_LAST) begin
                        state_d = (PARITY_EN != 0) ? RX_PARITY : RX_STOP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            RX_PARITY: begin
                if (clk_bps) begin
                    perr_d  = par_q ^ rx_s ^ ODD;
                    state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (clk_bps) begin
                    state_d = RX_IDLE;
                    bps_d   = 1'b0;
                    if (!rx_s) begin
                        ferr_d = 1'b1;
                    end else if (perr_q) begin
                        perr_p_d = 1'b1;
                    end else if (valid_q && !rx_ready) begin
                        ovr_d = 1'b1;
                    end else begin
                        data_d  = shreg_q;
                        valid_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = RX_IDLE;
                bps_d   = 1'b0;
            end
        endcase
    end

    assign bps_start  = bps_q;
    assign rx_data    = data_q;
    assign rx_valid   = valid_q;
    assign frame_err  = ferr_q;
    assign parity_err = perr_p_q;
    assign overrun    = ovr_q;

endmodule
